// File: rtl/line_refill_engine_if.sv
// ---------------------------------------------------------------------------
// line_refill_engine_if
//
// Bundles the I-cache miss request, the AHB-Lite read master bus, the early
// critical-word pulse and the line-fill handshake of line_refill_engine.
//
//   modport master : the refill engine side
//     in : miss_valid, miss_addr, hrdata, hready, hresp, fill_ready
//     out: miss_ready, haddr, htrans, hburst, hsize, hwrite,
//          crit_valid, crit_data, fill_valid, fill_addr, fill_data, fill_err
//   modport slave  : the environment side (cache control, AHB slave, array)
// ---------------------------------------------------------------------------
interface line_refill_engine_if #(
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
);
    // miss request
    logic                      miss_valid;
    logic [31:0]               miss_addr;
    logic                      miss_ready;
    // AHB-Lite master
    logic [31:0]               haddr;
    logic [1:0]                htrans;
    logic [2:0]                hburst;
    logic [2:0]                hsize;
    logic                      hwrite;
    logic [DATA_W-1:0]         hrdata;
    logic                      hready;
    logic                      hresp;
    // critical word early restart
    logic                      crit_valid;
    logic [DATA_W-1:0]         crit_data;
    // line fill towards the cache array
    logic                      fill_valid;
    logic                      fill_ready;
    logic [31:0]               fill_addr;
    logic [BEATS*DATA_W-1:0]   fill_data;
    logic                      fill_err;

    modport master (
        input  miss_valid, miss_addr, hrdata, hready, hresp, fill_ready,
        output miss_ready, haddr, htrans, hburst, hsize, hwrite,
               crit_valid, crit_data, fill_valid, fill_addr, fill_data, fill_err
    );

    modport slave (
        output miss_valid, miss_addr, hrdata, hready, hresp, fill_ready,
        input  miss_ready, haddr, htrans, hburst, hsize, hwrite,
               crit_valid, crit_data, fill_valid, fill_addr, fill_data, fill_err
    );
endinterface

// File: rtl/line_refill_engine.sv
// ---------------------------------------------------------------------------
// line_refill_engine
//
// AHB-Lite read-burst master for the I-cache miss path. A miss launches one
// WRAP4 critical-word-first burst; returned beats are collected in a line
// buffer and handed to the cache array over a valid/ready handshake. The
// first returned beat is also pulsed out early for core restart. An ERROR
// response cancels the rest of the burst and delivers a partial line with
// fill_err set.
//
// Ports:
//   clk   : system clock, rising edge
//   rstn  : asynchronous active-low reset
//   bus   : line_refill_engine_if.master (miss request, AHB bus, critical
//           word, line fill)
// ---------------------------------------------------------------------------
module line_refill_engine #(
    parameter int DATA_W = 32,
    parameter int BEATS  = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    line_refill_engine_if.master bus
);
    localparam int OFF_W    = $clog2(DATA_W / 8);   // byte offset within a word
    localparam int IDX_W    = $clog2(BEATS);        // word index within a line
    localparam int LINE_OFF = OFF_W + IDX_W;        // byte offset within a line
    localparam int CNT_W    = IDX_W + 1;

    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] NUM_BEATS  = CNT_W'(BEATS);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_BURST,
        S_DRAIN,
        S_FILL
    } state_t;

    state_t              state_q;
    logic [31:0]         haddr_q;
    logic [1:0]          htrans_q;
    logic [2:0]          hburst_q;
    logic [CNT_W-1:0]    addr_cnt_q;    // addresses accepted by the slave
    logic [CNT_W-1:0]    beat_cnt_q;    // data beats sampled
    logic [IDX_W-1:0]    start_idx_q;   // word index of the critical word
    logic                miss_ready_q;
    logic                crit_valid_q;
    logic [DATA_W-1:0]   crit_data_q;
    logic                fill_valid_q;
    logic                fill_err_q;
    logic [31:0]         fill_addr_q;
    logic [DATA_W-1:0]   line_q [BEATS];

    logic [IDX_W-1:0]    wrap_idx_d;
    logic [31:0]         haddr_d;
    logic [IDX_W-1:0]    beat_idx_d;
    logic                unused_addr_bits;

    // Wrapping increment: only the word-in-line index advances.
    always_comb begin
        wrap_idx_d = haddr_q[LINE_OFF-1:OFF_W] + IDX_W'(1);
        haddr_d    = {haddr_q[31:LINE_OFF], wrap_idx_d, {OFF_W{1'b0}}};
    end

    // Beats come back in wrap order, so beat n lands at start + n (mod BEATS),
    // which is exactly the [3:2] of the address that beat was issued with.
    always_comb begin
        beat_idx_d = start_idx_q + beat_cnt_q[IDX_W-1:0];
    end

    assign unused_addr_bits = ^bus.miss_addr[OFF_W-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            haddr_q      <= '0;
            htrans_q     <= HTRANS_IDLE;
            hburst_q     <= HBURST_SINGLE;
            addr_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            start_idx_q  <= '0;
            miss_ready_q <= 1'b1;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            fill_valid_q <= 1'b0;
            fill_err_q   <= 1'b0;
            fill_addr_q  <= '0;
            for (int i = 0; i < BEATS; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            crit_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.miss_valid) begin
                        haddr_q      <= {bus.miss_addr[31:OFF_W], {OFF_W{1'b0}}};
                        htrans_q     <= HTRANS_NONSEQ;
                        hburst_q     <= HBURST_WRAP4;
                        start_idx_q  <= bus.miss_addr[LINE_OFF-1:OFF_W];
                        fill_addr_q  <= {bus.miss_addr[31:LINE_OFF], {LINE_OFF{1'b0}}};
                        addr_cnt_q   <= '0;
                        beat_cnt_q   <= '0;
                        miss_ready_q <= 1'b0;
                        for (int i = 0; i < BEATS; i++) begin
                            line_q[i] <= '0;
                        end
                        state_q      <= S_ADDR;
                    end
                end

                // NONSEQ address phase; no data phase is outstanding yet.
                S_ADDR: begin
                    if (bus.hready) begin
                        addr_cnt_q <= CNT_W'(1);
                        haddr_q    <= haddr_d;
                        htrans_q   <= HTRANS_SEQ;
                        state_q    <= S_BURST;
                    end
                end

                // Every BURST cycle has exactly one data phase outstanding;
                // an address phase overlaps it until all addresses are out.
                S_BURST: begin
                    if (bus.hready) begin
                        if (addr_cnt_q < NUM_BEATS) begin
                            addr_cnt_q <= addr_cnt_q + CNT_W'(1);
                            if (addr_cnt_q == LAST_BEAT) begin
                                htrans_q <= HTRANS_IDLE;
                                hburst_q <= HBURST_SINGLE;
                            end else begin
                                haddr_q  <= haddr_d;
                            end
                        end
                        line_q[beat_idx_d] <= bus.hrdata;
                        beat_cnt_q         <= beat_cnt_q + CNT_W'(1);
                        if (beat_cnt_q == '0) begin
                            crit_valid_q <= 1'b1;
                            crit_data_q  <= bus.hrdata;
                        end
                        if (beat_cnt_q == LAST_BEAT) begin
                            fill_valid_q <= 1'b1;
                            state_q      <= S_FILL;
                        end
                    end else if (bus.hresp) begin
                        // First ERROR cycle: cancel the remaining transfers.
                        htrans_q <= HTRANS_IDLE;
                        hburst_q <= HBURST_SINGLE;
                        state_q  <= S_DRAIN;
                    end
                end

                // Second ERROR cycle completes the failed beat; its data is dropped.
                S_DRAIN: begin
                    if (bus.hresp && bus.hready) begin
                        fill_valid_q <= 1'b1;
                        fill_err_q   <= 1'b1;
                        state_q      <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (bus.fill_ready) begin
                        fill_valid_q <= 1'b0;
                        fill_err_q   <= 1'b0;
                        miss_ready_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.miss_ready = miss_ready_q;
    assign bus.haddr      = haddr_q;
    assign bus.htrans     = htrans_q;
    assign bus.hburst     = hburst_q;
    assign bus.hsize      = 3'b010;
    assign bus.hwrite     = 1'b0;
    assign bus.crit_valid = crit_valid_q;
    assign bus.crit_data  = crit_data_q;
    assign bus.fill_valid = fill_valid_q;
    assign bus.fill_addr  = fill_addr_q;
    assign bus.fill_err   = fill_err_q;

    // Word i of the line occupies fill_data[DATA_W*i +: DATA_W].
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_fill_word
        assign bus.fill_data[gi*DATA_W +: DATA_W] = line_q[gi];
    end
endmodule

// File: tb/tb_line_refill_engine.sv
// ---------------------------------------------------------------------------
// tb_line_refill_engine
//
// Directed bench for line_refill_engine. A small AHB slave inside tick()
// returns 0xCAFE_0000 | addr[15:0] for every accepted read address, with
// hready/hresp driven by the scenario tasks. Expected values are written
// out by hand per cycle; k counts cycles after the miss-accept edge (k=1 is
// the NONSEQ cycle).
// ---------------------------------------------------------------------------
module tb_line_refill_engine;
    logic clk  = 1'b0;
    logic rstn = 1'b0;

    line_refill_engine_if #(.DATA_W(32), .BEATS(4)) bus();

    line_refill_engine #(.DATA_W(32), .BEATS(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        dph_valid = 1'b0;
    logic [31:0] dph_addr  = '0;

    // One clock: capture the address phase seen by the slave, pass the edge,
    // then present data for the new data phase 1 ns later.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        logic        rdy;
        acc = bus.htrans[1];
        a   = bus.haddr;
        rdy = bus.hready;
        @(posedge clk);
        #1;
        if (rdy) begin
            dph_valid = acc;
            dph_addr  = a;
        end
        bus.hrdata = dph_valid ? (32'hCAFE_0000 | {16'h0, dph_addr[15:0]}) : 32'h0;
    endtask

    task automatic start_miss(input logic [31:0] a);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = a;
        tick();
        bus.miss_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.miss_valid = 1'b0;
        bus.miss_addr  = '0;
        bus.hrdata     = '0;
        bus.hready     = 1'b1;
        bus.hresp      = 1'b0;
        bus.fill_ready = 1'b1;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        checks++; if (bus.htrans !== 2'b00) begin failures++; $display("FAIL rst_htrans got=%b exp=00", bus.htrans); end
        checks++; if (bus.hburst !== 3'b000) begin failures++; $display("FAIL rst_hburst got=%b exp=000", bus.hburst); end
        checks++; if (bus.haddr !== 32'h0) begin failures++; $display("FAIL rst_haddr got=%h exp=0", bus.haddr); end
        checks++; if (bus.miss_ready !== 1'b1) begin failures++; $display("FAIL rst_miss_ready got=%b exp=1", bus.miss_ready); end
        checks++; if (bus.fill_valid !== 1'b0 || bus.fill_err !== 1'b0 || bus.crit_valid !== 1'b0) begin
            failures++; $display("FAIL rst_valids got fv=%b fe=%b cv=%b exp=0", bus.fill_valid, bus.fill_err, bus.crit_valid); end
        checks++; if (bus.fill_data !== 128'h0 || bus.fill_addr !== 32'h0) begin
            failures++; $display("FAIL rst_fill got data=%h addr=%h exp=0", bus.fill_data, bus.fill_addr); end
        checks++; if (bus.hsize !== 3'b010 || bus.hwrite !== 1'b0) begin
            failures++; $display("FAIL rst_const got hsize=%b hwrite=%b exp=010/0", bus.hsize, bus.hwrite); end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp_a [4];
        logic [1:0]  exp_tr;
        exp_a = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.fill_ready = 1'b1;
        start_miss(32'h0000_1008);
        for (int k = 1; k <= 7; k++) begin
            exp_tr = (k == 1) ? 2'b10 : (k <= 4) ? 2'b11 : 2'b00;
            checks++; if (bus.htrans !== exp_tr) begin failures++; $display("FAIL zw_htrans k=%0d got=%b exp=%b", k, bus.htrans, exp_tr); end
            checks++; if (bus.hburst !== ((k <= 4) ? 3'b010 : 3'b000)) begin failures++; $display("FAIL zw_hburst k=%0d got=%b", k, bus.hburst); end
            if (k <= 4) begin
                checks++; if (bus.haddr !== exp_a[k-1]) begin failures++; $display("FAIL zw_haddr k=%0d got=%h exp=%h", k, bus.haddr, exp_a[k-1]); end
            end
            checks++; if (bus.crit_valid !== (k == 3)) begin failures++; $display("FAIL zw_crit_valid k=%0d got=%b", k, bus.crit_valid); end
            checks++; if (bus.fill_valid !== (k == 6)) begin failures++; $display("FAIL zw_fill_valid k=%0d got=%b", k, bus.fill_valid); end
            checks++; if (bus.miss_ready !== (k == 7)) begin failures++; $display("FAIL zw_miss_ready k=%0d got=%b", k, bus.miss_ready); end
            if (k == 3) begin
                checks++; if (bus.crit_data !== 32'hCAFE1008) begin failures++; $display("FAIL zw_crit_data got=%h exp=cafe1008", bus.crit_data); end
            end
            if (k == 6) begin
                checks++; if (bus.fill_data !== 128'hCAFE100C_CAFE1008_CAFE1004_CAFE1000) begin
                    failures++; $display("FAIL zw_fill_data got=%h", bus.fill_data); end
                checks++; if (bus.fill_addr !== 32'h1000 || bus.fill_err !== 1'b0) begin
                    failures++; $display("FAIL zw_fill_addr got=%h err=%b exp=1000/0", bus.fill_addr, bus.fill_err); end
            end
            if (k < 7) tick();
        end
        $display("test_zero_wait done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_wait_states();
        logic [31:0] exp_a [6];
        logic [1:0]  exp_tr;
        exp_a = '{32'h1008, 32'h100C, 32'h1000, 32'h1000, 32'h1000, 32'h1004};
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.fill_ready = 1'b1;
        start_miss(32'h0000_1008);
        for (int k = 1; k <= 9; k++) begin
            exp_tr = (k == 1) ? 2'b10 : (k <= 6) ? 2'b11 : 2'b00;
            checks++; if (bus.htrans !== exp_tr) begin failures++; $display("FAIL ws_htrans k=%0d got=%b exp=%b", k, bus.htrans, exp_tr); end
            if (k <= 6) begin
                checks++; if (bus.haddr !== exp_a[k-1]) begin failures++; $display("FAIL ws_haddr k=%0d got=%h exp=%h", k, bus.haddr, exp_a[k-1]); end
            end
            checks++; if (bus.fill_valid !== (k == 8)) begin failures++; $display("FAIL ws_fill_valid k=%0d got=%b", k, bus.fill_valid); end
            if (k == 8) begin
                checks++; if (bus.fill_data !== 128'hCAFE100C_CAFE1008_CAFE1004_CAFE1000 || bus.fill_err !== 1'b0) begin
                    failures++; $display("FAIL ws_fill_data got=%h err=%b", bus.fill_data, bus.fill_err); end
            end
            bus.hready = !(k == 3 || k == 4);
            if (k < 9) tick();
        end
        bus.hready = 1'b1;
        $display("test_wait_states done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_fill_backpressure();
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.fill_ready = 1'b0;
        start_miss(32'h0000_5004);
        for (int k = 1; k <= 19; k++) begin
            if (k >= 6 && k <= 11) begin
                checks++; if (bus.fill_valid !== 1'b1 || bus.miss_ready !== 1'b0) begin
                    failures++; $display("FAIL bp_hold k=%0d got fv=%b mr=%b exp=1/0", k, bus.fill_valid, bus.miss_ready); end
                checks++; if (bus.fill_data !== 128'hCAFE500C_CAFE5008_CAFE5004_CAFE5000 || bus.fill_addr !== 32'h5000) begin
                    failures++; $display("FAIL bp_data k=%0d got=%h addr=%h", k, bus.fill_data, bus.fill_addr); end
            end
            if (k == 12) begin
                checks++; if (bus.fill_valid !== 1'b0 || bus.miss_ready !== 1'b1 || bus.htrans !== 2'b00) begin
                    failures++; $display("FAIL bp_idle got fv=%b mr=%b tr=%b exp=0/1/00", bus.fill_valid, bus.miss_ready, bus.htrans); end
            end
            if (k == 13) begin
                checks++; if (bus.htrans !== 2'b10 || bus.haddr !== 32'h6000 || bus.miss_ready !== 1'b0) begin
                    failures++; $display("FAIL bp_accept got tr=%b addr=%h mr=%b exp=10/6000/0", bus.htrans, bus.haddr, bus.miss_ready); end
            end
            if (k == 18) begin
                checks++; if (bus.fill_valid !== 1'b1 || bus.fill_addr !== 32'h6000 ||
                              bus.fill_data !== 128'hCAFE600C_CAFE6008_CAFE6004_CAFE6000) begin
                    failures++; $display("FAIL bp_second got fv=%b addr=%h data=%h", bus.fill_valid, bus.fill_addr, bus.fill_data); end
            end
            if (k == 6) begin bus.miss_valid = 1'b1; bus.miss_addr = 32'h0000_6000; end
            if (k == 11) bus.fill_ready = 1'b1;
            if (k == 13) bus.miss_valid = 1'b0;
            if (k < 19) tick();
        end
        $display("test_fill_backpressure done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_error();
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.fill_ready = 1'b1;
        start_miss(32'h0000_7000);
        for (int k = 1; k <= 7; k++) begin
            if (k == 3) begin
                checks++; if (bus.crit_valid !== 1'b1 || bus.crit_data !== 32'hCAFE7000) begin
                    failures++; $display("FAIL err2_crit got cv=%b data=%h exp=1/cafe7000", bus.crit_valid, bus.crit_data); end
            end
            if (k == 4) begin
                checks++; if (bus.htrans !== 2'b11 || bus.haddr !== 32'h700C) begin
                    failures++; $display("FAIL err2_addr got tr=%b addr=%h exp=11/700c", bus.htrans, bus.haddr); end
            end
            if (k == 5) begin
                checks++; if (bus.htrans !== 2'b00 || bus.hburst !== 3'b000) begin
                    failures++; $display("FAIL err2_cancel got tr=%b hb=%b exp=00/000", bus.htrans, bus.hburst); end
            end
            checks++; if (bus.fill_valid !== (k == 6)) begin failures++; $display("FAIL err2_fill_valid k=%0d got=%b", k, bus.fill_valid); end
            if (k == 6) begin
                checks++; if (bus.fill_err !== 1'b1 || bus.fill_data !== 128'h00000000_00000000_CAFE7004_CAFE7000) begin
                    failures++; $display("FAIL err2_line got err=%b data=%h", bus.fill_err, bus.fill_data); end
            end
            if (k == 7) begin
                checks++; if (bus.fill_err !== 1'b0 || bus.miss_ready !== 1'b1) begin
                    failures++; $display("FAIL err2_done got err=%b mr=%b exp=0/1", bus.fill_err, bus.miss_ready); end
            end
            bus.hready = (k != 4);
            bus.hresp  = (k == 4 || k == 5);
            if (k < 7) tick();
        end
        // ERROR on the very first beat: no critical word may escape.
        bus.hready = 1'b1; bus.hresp = 1'b0;
        start_miss(32'h0000_8000);
        for (int k = 1; k <= 5; k++) begin
            checks++; if (bus.crit_valid !== 1'b0) begin failures++; $display("FAIL err0_crit k=%0d got=%b exp=0", k, bus.crit_valid); end
            if (k == 3) begin
                checks++; if (bus.htrans !== 2'b00) begin failures++; $display("FAIL err0_cancel got=%b exp=00", bus.htrans); end
            end
            if (k == 4) begin
                checks++; if (bus.fill_valid !== 1'b1 || bus.fill_err !== 1'b1 || bus.fill_data !== 128'h0) begin
                    failures++; $display("FAIL err0_line got fv=%b err=%b data=%h", bus.fill_valid, bus.fill_err, bus.fill_data); end
            end
            bus.hready = (k != 2);
            bus.hresp  = (k == 2 || k == 3);
            if (k < 5) tick();
        end
        bus.hready = 1'b1; bus.hresp = 1'b0;
        $display("test_error done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_async_reset();
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.fill_ready = 1'b1;
        start_miss(32'h0000_1008);
        tick();
        checks++; if (bus.htrans !== 2'b11) begin failures++; $display("FAIL ar_pre got=%b exp=11", bus.htrans); end
        rstn = 1'b0;
        #1;
        checks++; if (bus.htrans !== 2'b00 || bus.hburst !== 3'b000 || bus.haddr !== 32'h0) begin
            failures++; $display("FAIL ar_bus got tr=%b hb=%b addr=%h exp=00/000/0", bus.htrans, bus.hburst, bus.haddr); end
        checks++; if (bus.fill_valid !== 1'b0 || bus.crit_valid !== 1'b0) begin
            failures++; $display("FAIL ar_valid got fv=%b cv=%b exp=0/0", bus.fill_valid, bus.crit_valid); end
        dph_valid  = 1'b0;
        bus.hrdata = '0;
        tick();
        rstn = 1'b1;
        tick();
        checks++; if (bus.miss_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", bus.miss_ready); end
        start_miss(32'h0000_2000);
        for (int k = 1; k <= 7; k++) begin
            checks++; if (bus.fill_valid !== (k == 6)) begin failures++; $display("FAIL ar_fill_valid k=%0d got=%b", k, bus.fill_valid); end
            if (k == 3) begin
                checks++; if (bus.crit_data !== 32'hCAFE2000) begin failures++; $display("FAIL ar_crit got=%h exp=cafe2000", bus.crit_data); end
            end
            if (k == 6) begin
                checks++; if (bus.fill_addr !== 32'h2000 || bus.fill_err !== 1'b0 ||
                              bus.fill_data !== 128'hCAFE200C_CAFE2008_CAFE2004_CAFE2000) begin
                    failures++; $display("FAIL ar_line got addr=%h err=%b data=%h", bus.fill_addr, bus.fill_err, bus.fill_data); end
            end
            if (k < 7) tick();
        end
        $display("test_async_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a [14];
        logic [1:0]  exp_tr [14];
        exp_a  = '{32'h3004, 32'h3008, 32'h300C, 32'h3000, 32'h0, 32'h0, 32'h0,
                   32'h400C, 32'h4000, 32'h4004, 32'h4008, 32'h0, 32'h0, 32'h0};
        exp_tr = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00,
                   2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.fill_ready = 1'b1;
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h0000_3004;
        tick();
        bus.miss_addr  = 32'h0000_400C;
        for (int k = 1; k <= 14; k++) begin
            checks++; if (bus.htrans !== exp_tr[k-1]) begin failures++; $display("FAIL b2b_htrans k=%0d got=%b exp=%b", k, bus.htrans, exp_tr[k-1]); end
            if (exp_tr[k-1] != 2'b00) begin
                checks++; if (bus.haddr !== exp_a[k-1]) begin failures++; $display("FAIL b2b_haddr k=%0d got=%h exp=%h", k, bus.haddr, exp_a[k-1]); end
            end
            checks++; if (bus.miss_ready !== (k == 7 || k == 14)) begin failures++; $display("FAIL b2b_miss_ready k=%0d got=%b", k, bus.miss_ready); end
            checks++; if (bus.fill_valid !== (k == 6 || k == 13)) begin failures++; $display("FAIL b2b_fill_valid k=%0d got=%b", k, bus.fill_valid); end
            if (k == 6) begin
                checks++; if (bus.fill_addr !== 32'h3000 || bus.fill_data !== 128'hCAFE300C_CAFE3008_CAFE3004_CAFE3000) begin
                    failures++; $display("FAIL b2b_line1 got addr=%h data=%h", bus.fill_addr, bus.fill_data); end
            end
            if (k == 13) begin
                checks++; if (bus.fill_addr !== 32'h4000 || bus.fill_data !== 128'hCAFE400C_CAFE4008_CAFE4004_CAFE4000) begin
                    failures++; $display("FAIL b2b_line2 got addr=%h data=%h", bus.fill_addr, bus.fill_data); end
            end
            if (k == 8) bus.miss_valid = 1'b0;
            if (k < 14) tick();
        end
        $display("test_back_to_back done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_fill_backpressure();
        test_error();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
